oh_fifo_sync_ctrl: RTL
======================

# oh_fifo_sync_ctrl

Single-clock FIFO controller that owns the pointers, flags and occupancy count for a dual-port memory instance (oh_memory_dp / oh_memory_ram) and drives its write and read ports directly. It sits between an upstream producer (write side) and a downstream consumer (read side) and turns the raw dual-port array into a flow-controlled FIFO. Memory read data is registered inside the memory, so this block adds exactly one cycle of read latency and presents a `valid` strobe alongside it.

## Interface
- `DW`, 104, data width; must match the memory `DW`.
- `DEPTH`, 32, entries; power of two, ≥4.
- `AW`, 5, address width; equals log2(`DEPTH`).
- `PROG_FULL`, `DEPTH`-4, occupancy at or above which `prog_full` asserts.
- `clk`  in  1  single clock; memory `wr_clk` and `rd_clk` are both tied to it.
- `nreset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush; empties the FIFO.
- `wr_en`  in  1  producer write request.
- `din`  in  DW  write data.
- `full`  out  1  no free entries.
- `prog_full`  out  1  count ≥ `PROG_FULL`.
- `rd_en`  in  1  consumer read request.
- `dout`  out  DW  read data (memory `rd_dout` passthrough).
- `valid`  out  1  `dout` holds the entry popped last cycle.
- `empty`  out  1  no stored entries.
- `count`  out  AW+1  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky: write attempted while full.
- `underflow`  out  1  sticky: read attempted while empty.
- `mem_wr_en`, `mem_wr_addr`[AW], `mem_wr_din`[DW], `mem_wr_wem`[DW]  out  memory write port.
- `mem_rd_en`, `mem_rd_addr`[AW]  out  memory read port.
- `mem_rd_dout`  in  DW  memory read data.

## Operation
- Pointers `wr_ptr`, `rd_ptr` are AW+1 bits; low AW bits address memory, MSB is the wrap bit.
- Write accepted: `wr_go = wr_en & ~full & ~clear`. Drives `mem_wr_en=wr_go`, `mem_wr_addr=wr_ptr[AW-1:0]`, `mem_wr_din=din`, `mem_wr_wem` all ones; `wr_ptr` increments.
- Read accepted: `rd_go = rd_en & ~empty & ~clear`. Drives `mem_rd_en=rd_go`, `mem_rd_addr=rd_ptr[AW-1:0]`; `rd_ptr` increments.
- `full`/`empty` are decided on the registered flags of the current cycle only: write while full is dropped even if a read is accepted in the same cycle; read while empty is dropped even if a write is accepted in the same cycle.
- `count` next = count + `wr_go` − `rd_go`; both accepted → unchanged.
- `empty` = (`wr_ptr`==`rd_ptr`); `full` = low bits equal and MSBs differ; both registered from next-state pointers.
- `prog_full` registered from next `count`.
- `overflow` sets on `wr_en & full`; `underflow` sets on `rd_en & empty`; both cleared only by reset or `clear`.
- Pointers wrap from `DEPTH`-1 to 0 with MSB toggle; no special handling beyond that.
- `clear`: next cycle pointers=0, count=0, `empty`=1, `full`=0, `prog_full`=0, `valid`=0, sticky flags=0; concurrent `wr_en`/`rd_en` ignored.

## Timing
- Reset values: `full`=0, `empty`=1, `prog_full`=0, `valid`=0, `count`=0, `overflow`=0, `underflow`=0, pointers 0. `mem_*_en` are combinational and are 0 during reset because `empty`=1 blocks reads and reset forces `wr_go`=0.
- Write in cycle N: `empty` deasserts and `count` updates at edge N+1.
- Read accepted in cycle N: `dout` valid and `valid`=1 in cycle N+1 (one-cycle latency); back-to-back reads give one word per cycle.
- Last free slot written in cycle N: `full`=1 from N+1.
- `nreset` asserted mid-transfer: all state returns to reset values immediately; an in-flight read's `valid` is dropped.

## Test plan
- Reset, then write 0x1..0x4 on consecutive cycles, then read 4 → `dout` 0x1..0x4 on cycles after each read, `valid`=1 each, `empty`=1 and `count`=0 at end.
- Fill 32 entries → `full`=1 after the 32nd, `prog_full`=1 from `count`=28; 33rd write → dropped, `overflow`=1, `count` stays 32.
- Empty FIFO, `rd_en`=1 → no `mem_rd_en`, `valid`=0, `underflow`=1.
- Hold `count`=16, assert `wr_en`+`rd_en` for 100 cycles with incrementing data → `count` stays 16, data order preserved across pointer wrap.
- Full FIFO with simultaneous write+read → read accepted, write dropped, `overflow`=1, `count`=31; then `clear` → `count`=0, `empty`=1, flags 0.
- Assert `nreset` low for one cycle mid-stream with `count`=10 → all outputs at reset values next cycle, `valid`=0.

Source files
------------

// File: rtl/oh_fifo_sync_ctrl.sv
// Single-clock FIFO controller: pointers, flags and occupancy for an external dual-port
// memory with registered read data, adding one cycle of read latency plus a valid strobe.
module oh_fifo_sync_ctrl #(
    parameter int DW        = 104,
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int PROG_FULL = DEPTH - 4
) (
    input  logic          clk_i,
    input  logic          nreset_i,
    input  logic          clear_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] din_i,
    output logic          full_o,
    output logic          prog_full_o,
    input  logic          rd_en_i,
    output logic [DW-1:0] dout_o,
    output logic          valid_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o,
    output logic          underflow_o,
    output logic          mem_wr_en_o,
    output logic [AW-1:0] mem_wr_addr_o,
    output logic [DW-1:0] mem_wr_din_o,
    output logic [DW-1:0] mem_wr_wem_o,
    output logic          mem_rd_en_o,
    output logic [AW-1:0] mem_rd_addr_o,
    input  logic [DW-1:0] mem_rd_dout_i
);

    localparam logic [AW:0] PROG_FULL_LVL = (AW+1)'(PROG_FULL);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        prog_full_q, prog_full_d;
    logic        valid_q, valid_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        wr_go;
    logic        rd_go;

    // Handshake: wr_en is honoured only when the registered full flag is low and rd_en only
    // when the registered empty flag is low; a refused request is dropped and sets a sticky flag.
    assign wr_go = wr_en_i & ~full_q & ~clear_i & nreset_i;
    assign rd_go = rd_en_i & ~empty_q & ~clear_i & nreset_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (AW+1)'(wr_go);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(rd_go);
        count_d     = count_q + (AW+1)'(wr_go) - (AW+1)'(rd_go);
        overflow_d  = overflow_q | (wr_en_i & full_q);
        underflow_d = underflow_q | (rd_en_i & empty_q);
        valid_d     = rd_go;
        if (clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        empty_d     = (wr_ptr_d == rd_ptr_d);
        full_d      = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        prog_full_d = (count_d >= PROG_FULL_LVL);
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            prog_full_q <= 1'b0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            prog_full_q <= prog_full_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign mem_wr_en_o   = wr_go;
    assign mem_wr_addr_o = wr_ptr_q[AW-1:0];
    assign mem_wr_din_o  = din_i;
    assign mem_wr_wem_o  = '1;
    assign mem_rd_en_o   = rd_go;
    assign mem_rd_addr_o = rd_ptr_q[AW-1:0];

    assign dout_o      = mem_rd_dout_i;
    assign valid_o     = valid_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign prog_full_o = prog_full_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule
